// File: rtl/laser_cover_check.sv
`default_nettype none
// ============================================================================
//  Module      : laser_cover_check
//  Description : Buffers a 40-point target stream, latches the two laser
//                circle centres on DONE, then sweeps the stored points one per
//                cycle counting how many fall inside C1 or C2 (COVER_CNT) and
//                inside both (OVERLAP_CNT). The result is held until accepted.
//  Options     : LASER_COVER_OVERLAP_EN - builds the overlap test and counter;
//                when undefined OVERLAP_CNT is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module laser_cover_check (
    input  logic       CLK,
    input  logic       RST,
    input  logic       IN_VALID,
    input  logic [3:0] X,
    input  logic [3:0] Y,
    input  logic [3:0] C1X,
    input  logic [3:0] C1Y,
    input  logic [3:0] C2X,
    input  logic [3:0] C2Y,
    input  logic       DONE,
    input  logic       RES_READY,
    output logic [5:0] COVER_CNT,
    output logic [5:0] OVERLAP_CNT,
    output logic       RES_VALID,
    output logic       BUSY,
    output logic       ERR
);

    localparam int         c_ITEM_NUM  = 40;
    localparam int         c_RADIUS    = 4;
    localparam logic [9:0] c_RADIUS_SQ = 10'(c_RADIUS * c_RADIUS);
    localparam logic [5:0] c_LAST_IDX  = 6'(c_ITEM_NUM - 1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_LOAD      = 3'd1;
    localparam logic [2:0] c_WAIT_DONE = 3'd2;
    localparam logic [2:0] c_EVAL      = 3'd3;
    localparam logic [2:0] c_HOLD      = 3'd4;

    logic [2:0] r_state;
    logic [5:0] r_idx;
    logic [3:0] r_pt_x [0:c_ITEM_NUM-1];
    logic [3:0] r_pt_y [0:c_ITEM_NUM-1];
    logic [3:0] r_c1x;
    logic [3:0] r_c1y;
    logic [3:0] r_c2x;
    logic [3:0] r_c2y;
    logic [5:0] r_cover_cnt;
    logic       r_res_valid;
    logic       r_err;

    logic       w_store;
    logic       w_start_eval;
    logic [3:0] w_ex;
    logic [3:0] w_ey;
    logic       w_in_c1;
    logic       w_in_c2;

    // Squared-distance test; differences taken at 5-bit signed width so the
    // full 0..15 range of each coordinate difference is representable.
    function automatic logic f_inside(input logic [3:0] px, input logic [3:0] py,
                                      input logic [3:0] cx, input logic [3:0] cy);
        logic signed [4:0] dx;
        logic signed [4:0] dy;
        logic [4:0]        adx;
        logic [4:0]        ady;
        logic [9:0]        sq;
        dx  = $signed({1'b0, px}) - $signed({1'b0, cx});
        dy  = $signed({1'b0, py}) - $signed({1'b0, cy});
        adx = dx[4] ? 5'(-dx) : 5'(dx);
        ady = dy[4] ? 5'(-dy) : 5'(dy);
        sq  = 10'(adx) * 10'(adx) + 10'(ady) * 10'(ady);
        return (sq <= c_RADIUS_SQ);
    endfunction

    // Points are only accepted while collecting; IDLE always writes slot 0.
    assign w_store      = IN_VALID && ((r_state == c_IDLE) || (r_state == c_LOAD));
    assign w_start_eval = (r_state == c_WAIT_DONE) && DONE;

    assign w_ex    = r_pt_x[r_idx];
    assign w_ey    = r_pt_y[r_idx];
    assign w_in_c1 = f_inside(w_ex, w_ey, r_c1x, r_c1y);
    assign w_in_c2 = f_inside(w_ex, w_ey, r_c2x, r_c2y);

    // Point storage; contents are don't-care until a full load overwrites them.
    always_ff @(posedge CLK) begin
        if (w_store) begin
            r_pt_x[(r_state == c_IDLE) ? 6'd0 : r_idx] <= X;
            r_pt_y[(r_state == c_IDLE) ? 6'd0 : r_idx] <= Y;
        end
    end

    // Control FSM: index sequencing, centre latch, result handshake, error pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= c_IDLE;
            r_idx       <= 6'd0;
            r_c1x       <= 4'd0;
            r_c1y       <= 4'd0;
            r_c2x       <= 4'd0;
            r_c2y       <= 4'd0;
            r_res_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (DONE) begin
                        r_err <= 1'b1;
                    end
                    if (IN_VALID) begin
                        r_idx   <= 6'd1;
                        r_state <= c_LOAD;
                    end
                end
                c_LOAD: begin
                    if (DONE) begin
                        r_err <= 1'b1;
                    end
                    if (IN_VALID) begin
                        if (r_idx == c_LAST_IDX) begin
                            r_idx   <= 6'd0;
                            r_state <= c_WAIT_DONE;
                        end else begin
                            r_idx <= r_idx + 6'd1;
                        end
                    end
                end
                c_WAIT_DONE: begin
                    if (DONE) begin
                        r_c1x   <= C1X;
                        r_c1y   <= C1Y;
                        r_c2x   <= C2X;
                        r_c2y   <= C2Y;
                        r_idx   <= 6'd0;
                        r_state <= c_EVAL;
                    end
                end
                c_EVAL: begin
                    if (r_idx == c_LAST_IDX) begin
                        r_idx       <= 6'd0;
                        r_res_valid <= 1'b1;
                        r_state     <= c_HOLD;
                    end else begin
                        r_idx <= r_idx + 6'd1;
                    end
                end
                c_HOLD: begin
                    if (RES_READY) begin
                        r_res_valid <= 1'b0;
                        r_idx       <= 6'd0;
                        r_state     <= c_IDLE;
                    end
                end
                default: begin
                    r_idx   <= 6'd0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Coverage accumulator: cleared when the centres are latched, bumped per swept point.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cover_cnt <= 6'd0;
        end else if (w_start_eval) begin
            r_cover_cnt <= 6'd0;
        end else if ((r_state == c_EVAL) && (w_in_c1 || w_in_c2)) begin
            r_cover_cnt <= r_cover_cnt + 6'd1;
        end
    end

`ifdef LASER_COVER_OVERLAP_EN
    logic [5:0] r_overlap_cnt;

    // Overlap accumulator: same timing as coverage, counts points in both circles.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_overlap_cnt <= 6'd0;
        end else if (w_start_eval) begin
            r_overlap_cnt <= 6'd0;
        end else if ((r_state == c_EVAL) && w_in_c1 && w_in_c2) begin
            r_overlap_cnt <= r_overlap_cnt + 6'd1;
        end
    end

    assign OVERLAP_CNT = r_overlap_cnt;
`else
    assign OVERLAP_CNT = 6'd0;
`endif

    assign COVER_CNT = r_cover_cnt;
    assign RES_VALID = r_res_valid;
    assign BUSY      = (r_state != c_IDLE);
    assign ERR       = r_err;

endmodule
`default_nettype wire
